// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: bundles the requester handshakes, the MAR/RAM strobes
// and the status outputs of mem_access_ctrl.
//   slave  modport : used by the controller (requests in, acks/strobes out)
//   master modport : used by the requester/RAM side
// Parameters: ADDR_W (RAM word-address width), DATA_W (data/bus width).
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] rdata;
    logic              mar_in;
    logic [DATA_W-1:0] mar_bus;
    logic              ram_rd;
    logic              ram_wr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;
    logic              grant_d;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output if_ack, d_ack, rdata, mar_in, mar_bus, ram_rd, ram_wr,
               ram_wdata, busy, grant_d
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  if_ack, d_ack, rdata, mar_in, mar_bus, ram_rd, ram_wr,
               ram_wdata, busy, grant_d
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates one RAM port between instruction fetch (IF)
// and data load/store (D). A grant loads MAR in the same cycle, the RAM
// strobe is then held for RAM_LAT cycles, read data is captured on the last
// strobe cycle and the owner is acked for one cycle.
//
// Ports:
//   clk  - clock, rising edge
//   clr  - asynchronous active-low reset
//   bus  - mem_access_ctrl_if.slave (requests, acks, MAR/RAM strobes,
//          rdata, busy, grant_d)
// Parameters: RAM_LAT (1..15), ADDR_W, DATA_W.
// Optional macro MEM_ACCESS_RR_ARB_EN: round-robin arbitration instead of
// fixed D-over-IF priority.
//
// state  | meaning
// IDLE   | waiting; a pending request is granted and MAR loaded this cycle
// ACCESS | RAM strobe held for RAM_LAT cycles
// RESP   | one-cycle ack to the owner; rdata valid for reads
module mem_access_ctrl #(
    parameter int RAM_LAT = 2,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32
) (
    input logic              clk,
    input logic              clr,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(RAM_LAT - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              owner_d;
    logic              we_q;
    logic              any_req;
    logic              pick_d;
    logic              grant_now;
    logic [ADDR_W-1:0] win_addr;

    assign any_req = bus.if_req | bus.d_req;

`ifdef MEM_ACCESS_RR_ARB_EN
    // Pointer resets to "D granted last" so IF wins the first tie.
    logic last_d;

    always_comb begin
        pick_d = bus.d_req;
        if (bus.if_req && bus.d_req)
            pick_d = ~last_d;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            last_d <= 1'b1;
        else if (state == IDLE && any_req)
            last_d <= pick_d;
    end
`else
    assign pick_d = bus.d_req;
`endif

    // MAR load happens in the grant cycle itself, so it is decoded from the
    // live request; clr gates it so every output is 0 while held in reset.
    assign grant_now   = clr && (state == IDLE) && any_req;
    assign win_addr    = pick_d ? bus.d_addr : bus.if_addr;
    assign bus.mar_in  = grant_now;
    assign bus.mar_bus = grant_now ? {{(DATA_W-ADDR_W){1'b0}}, win_addr} : '0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            owner_d       <= 1'b0;
            we_q          <= 1'b0;
            bus.ram_rd    <= 1'b0;
            bus.ram_wr    <= 1'b0;
            bus.ram_wdata <= '0;
            bus.if_ack    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.rdata     <= '0;
            bus.busy      <= 1'b0;
            bus.grant_d   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.if_ack <= 1'b0;
                    bus.d_ack  <= 1'b0;
                    if (any_req) begin
                        owner_d     <= pick_d;
                        we_q        <= pick_d & bus.d_we;
                        bus.grant_d <= pick_d;
                        bus.busy    <= 1'b1;
                        cnt         <= CNT_INIT;
                        state       <= ACCESS;
                        if (pick_d && bus.d_we) begin
                            bus.ram_wr    <= 1'b1;
                            bus.ram_wdata <= bus.d_wdata;
                        end else begin
                            bus.ram_rd <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        bus.ram_rd    <= 1'b0;
                        bus.ram_wr    <= 1'b0;
                        bus.ram_wdata <= '0;
                        if (!we_q)
                            bus.rdata <= bus.ram_rdata;
                        bus.if_ack <= ~owner_d;
                        bus.d_ack  <= owner_d;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    bus.if_ack <= 1'b0;
                    bus.d_ack  <= 1'b0;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
